// File: rtl/triangle_setup_engine.sv
// Triangle setup: latches vertices, computes 2x signed area and an 8.24 inverse area
// with a serial restoring divider. Optional back-face culling via TRI_BACKFACE_CULL_EN.
module triangle_setup_engine #(
    parameter int FRAC_BITS = 24,
    parameter int CNT_W     = 16
) (
    input  logic             axi_aclk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_v1x,
    input  logic [8:0]       in_v2x,
    input  logic [8:0]       in_v3x,
    input  logic [7:0]       in_v1y,
    input  logic [7:0]       in_v2y,
    input  logic [7:0]       in_v3y,
    input  logic [15:0]      in_z1,
    input  logic [15:0]      in_z2,
    input  logic [15:0]      in_z3,
    input  logic [7:0]       in_color,
    output logic [8:0]       v1x,
    output logic [8:0]       v2x,
    output logic [8:0]       v3x,
    output logic [7:0]       v1y,
    output logic [7:0]       v2y,
    output logic [7:0]       v3y,
    output logic [15:0]      z1,
    output logic [15:0]      z2,
    output logic [15:0]      z3,
    output logic [7:0]       color,
    output logic [31:0]      inv_area,
    output logic             triangle_valid,
    input  logic             triangle_ready,
    output logic             busy,
    output logic [CNT_W-1:0] degenerate_count
);
    localparam int DW = $clog2(FRAC_BITS + 1);

    typedef enum logic [1:0] {IDLE, AREA, DIV, OUT} state_t;
    state_t state, state_nx;

    logic signed [19:0] area2_r, area2_c;
    logic signed [19:0] ax1, ax2, ax3, ay1, ay2, ay3;
    logic [19:0]        div_d, rem_r, rem_nx;
    logic [20:0]        rem_sh;
    logic               rem_ge, drop;
    logic [FRAC_BITS:0] quo_r, quo_nx;
    logic [DW-1:0]      cnt_r;

    // Operands are taken from the output registers, latched on acceptance.
    assign ax1 = signed'({11'd0, v1x});
    assign ax2 = signed'({11'd0, v2x});
    assign ax3 = signed'({11'd0, v3x});
    assign ay1 = signed'({12'd0, v1y});
    assign ay2 = signed'({12'd0, v2y});
    assign ay3 = signed'({12'd0, v3y});
    assign area2_c = ax1 * (ay2 - ay3) + ax2 * (ay3 - ay1) + ax3 * (ay1 - ay2);

`ifdef TRI_BACKFACE_CULL_EN
    assign drop = (area2_c == 20'sd0) || area2_c[19];
`else
    assign drop = (area2_c == 20'sd0);
`endif

    // One quotient bit per cycle; the dividend 2^FRAC_BITS feeds a single 1 on the first step.
    assign div_d  = area2_r[19] ? 20'(-area2_r) : 20'(area2_r);
    assign rem_sh = {rem_r, (cnt_r == DW'(FRAC_BITS))};
    assign rem_ge = (rem_sh >= {1'b0, div_d});
    assign rem_nx = rem_ge ? 20'(rem_sh - {1'b0, div_d}) : rem_sh[19:0];
    assign quo_nx = {quo_r[FRAC_BITS-1:0], rem_ge};

    assign in_ready       = (state == IDLE);
    assign busy           = (state != IDLE);
    assign triangle_valid = (state == OUT);

    always_ff @(posedge axi_aclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = AREA;
            AREA: state_nx = drop ? IDLE : DIV;
            DIV:  if (cnt_r == '0) state_nx = OUT;
            OUT:  if (triangle_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            {v1x, v2x, v3x}  <= '0;
            {v1y, v2y, v3y}  <= '0;
            {z1, z2, z3}     <= '0;
            color            <= '0;
            inv_area         <= '0;
            degenerate_count <= '0;
            area2_r          <= '0;
            rem_r            <= '0;
            quo_r            <= '0;
            cnt_r            <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    v1x <= in_v1x; v2x <= in_v2x; v3x <= in_v3x;
                    v1y <= in_v1y; v2y <= in_v2y; v3y <= in_v3y;
                    z1  <= in_z1;  z2  <= in_z2;  z3  <= in_z3;
                    color <= in_color;
                end
                AREA: begin
                    area2_r <= area2_c;
                    rem_r   <= '0;
                    quo_r   <= '0;
                    cnt_r   <= DW'(FRAC_BITS);
                    if (drop) degenerate_count <= degenerate_count + 1'b1;
                end
                DIV: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    cnt_r <= cnt_r - 1'b1;
                    if (cnt_r == '0) inv_area <= 32'(quo_nx);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_setup_engine.sv
// Directed bench for triangle_setup_engine: vector table plus stall and mid-divide reset sequences.
module tb_triangle_setup_engine;
    logic        axi_aclk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [8:0]  in_v1x = 0, in_v2x = 0, in_v3x = 0;
    logic [7:0]  in_v1y = 0, in_v2y = 0, in_v3y = 0;
    logic [15:0] in_z1 = 0, in_z2 = 0, in_z3 = 0;
    logic [7:0]  in_color = 0;
    logic [8:0]  v1x, v2x, v3x;
    logic [7:0]  v1y, v2y, v3y;
    logic [15:0] z1, z2, z3;
    logic [7:0]  color;
    logic [31:0] inv_area;
    logic        triangle_valid;
    logic        triangle_ready = 1;
    logic        busy;
    logic [15:0] degenerate_count;

    int checks = 0;
    int errors = 0;

    triangle_setup_engine dut (
        .axi_aclk(axi_aclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_v1x(in_v1x), .in_v2x(in_v2x), .in_v3x(in_v3x),
        .in_v1y(in_v1y), .in_v2y(in_v2y), .in_v3y(in_v3y),
        .in_z1(in_z1), .in_z2(in_z2), .in_z3(in_z3), .in_color(in_color),
        .v1x(v1x), .v2x(v2x), .v3x(v3x), .v1y(v1y), .v2y(v2y), .v3y(v3y),
        .z1(z1), .z2(z2), .z3(z3), .color(color), .inv_area(inv_area),
        .triangle_valid(triangle_valid), .triangle_ready(triangle_ready),
        .busy(busy), .degenerate_count(degenerate_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [8:0]  x1, x2, x3;
        logic [7:0]  y1, y2, y3;
        logic [15:0] za, zb, zc;
        logic [7:0]  col;
        logic [31:0] inv;
        bit          drop;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_v1x = v.x1; in_v2x = v.x2; in_v3x = v.x3;
        in_v1y = v.y1; in_v2y = v.y2; in_v3y = v.y3;
        in_z1 = v.za; in_z2 = v.zb; in_z3 = v.zc;
        in_color = v.col;
        in_valid = 1;
    endtask

    task automatic chk_fields(input vec_t v);
        chk("v1x", v1x, v.x1); chk("v2x", v2x, v.x2); chk("v3x", v3x, v.x3);
        chk("v1y", v1y, v.y1); chk("v2y", v2y, v.y2); chk("v3y", v3y, v.y3);
        chk("z1", z1, v.za); chk("z2", z2, v.zb); chk("z3", z3, v.zc);
        chk("color", color, v.col);
        chk("inv_area", inv_area, v.inv);
    endtask

    // Counts negedges after the accept edge until triangle_valid; returns 0 on timeout.
    task automatic wait_valid(output int lat);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 60) begin
            @(negedge axi_aclk);
            n++;
            if (triangle_valid) seen = 1;
        end
        lat = seen ? n : 0;
    endtask

    task automatic run_tri(input vec_t v);
        int lat;
        logic [15:0] cnt0;
        int guard = 0;
        @(negedge axi_aclk);
        while (!in_ready && guard < 100) begin @(negedge axi_aclk); guard++; end
        chk("in_ready_before", in_ready, 1);
        drive(v);
        cnt0 = degenerate_count;
        @(posedge axi_aclk);
        #1 in_valid = 0;
        if (v.drop) begin
            @(negedge axi_aclk);
            chk("in_ready_area", in_ready, 0);
            @(negedge axi_aclk);
            chk("in_ready_t2", in_ready, 1);
            chk("degen_count", degenerate_count, 32'(cnt0 + 16'd1));
            chk("drop_no_valid", triangle_valid, 0);
        end else begin
            wait_valid(lat);
            chk("latency", lat, 27);
            chk_fields(v);
            chk("degen_unchanged", degenerate_count, cnt0);
            if (triangle_ready) begin
                @(negedge axi_aclk);
                chk("valid_drop", triangle_valid, 0);
                chk("in_ready_after", in_ready, 1);
            end
        end
    endtask

    initial begin
        int lat;
        tbl[0] = '{9'd40, 9'd140, 9'd40, 8'd20, 8'd120, 8'd120, 16'd50, 16'd50, 16'd50, 8'hE0, 32'd1677, 0};
`ifdef TRI_BACKFACE_CULL_EN
        tbl[1] = '{9'd140, 9'd90, 9'd190, 8'd20, 8'd70, 8'd70, 16'd100, 16'd200, 16'd300, 8'h1C, 32'd3355, 1};
`else
        tbl[1] = '{9'd140, 9'd90, 9'd190, 8'd20, 8'd70, 8'd70, 16'd100, 16'd200, 16'd300, 8'h1C, 32'd3355, 0};
`endif
        tbl[2] = '{9'd20, 9'd70, 9'd20, 8'd140, 8'd200, 8'd200, 16'd7, 16'd8, 16'd9, 8'h03, 32'd5592, 0};
        tbl[3] = '{9'd0, 9'd10, 9'd20, 8'd0, 8'd10, 8'd20, 16'd1, 16'd2, 16'd3, 8'hFF, 32'd0, 1};
        tbl[4] = '{9'd0, 9'd1, 9'd0, 8'd0, 8'd0, 8'd1, 16'hFFFF, 16'd0, 16'h8000, 8'h55, 32'd16777216, 0};

        repeat (3) @(negedge axi_aclk);
        reset = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", triangle_valid, 0);
        chk("rst_inv", inv_area, 0);
        chk("rst_count", degenerate_count, 0);
        chk("rst_v1x", v1x, 0);

        for (int i = 0; i < 5; i++) run_tri(tbl[i]);

        // Rasterizer stall: record must hold, a second request must wait for the handshake.
        triangle_ready = 0;
        run_tri(tbl[2]);
        drive(tbl[4]);
        for (int c = 0; c < 50; c++) begin
            @(negedge axi_aclk);
            chk("stall_valid", triangle_valid, 1);
            chk("stall_inv", inv_area, 5592);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_v1y", v1y, 140);
        end
        triangle_ready = 1;
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("hs_valid", triangle_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_fields_held", v2y, 200);
        @(posedge axi_aclk);
        #1 in_valid = 0;
        wait_valid(lat);
        chk("second_latency", lat, 27);
        chk_fields(tbl[4]);
        @(negedge axi_aclk);
        chk("second_valid_drop", triangle_valid, 0);

        // Reset in the middle of the divide discards the triangle.
        @(negedge axi_aclk);
        drive(tbl[0]);
        @(posedge axi_aclk);
        #1 in_valid = 0;
        repeat (10) @(negedge axi_aclk);
        chk("mid_busy", busy, 1);
        reset = 1;
        @(negedge axi_aclk);
        chk("mrst_valid", triangle_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_inv", inv_area, 0);
        chk("mrst_count", degenerate_count, 0);
        reset = 0;
        repeat (3) @(negedge axi_aclk);
        chk("mrst_no_emit", triangle_valid, 0);
        run_tri(tbl[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
